// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants for the DMEM responder: peripheral register
//                word offsets, TIMER_CTRL bit positions and default window base.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // Default byte address of the 32-byte peripheral window
    localparam logic [31:0] DEFAULT_PERIPH_BASE = 32'h0001_0000;

    // Register offsets inside the window, as word index (byte offset >> 2)
    localparam logic [2:0] OFF_GPIO_OUT = 3'd0;   // 0x00
    localparam logic [2:0] OFF_GPIO_IN  = 3'd1;   // 0x04
    localparam logic [2:0] OFF_TCOUNT   = 3'd2;   // 0x08
    localparam logic [2:0] OFF_TCMP     = 3'd3;   // 0x0C
    localparam logic [2:0] OFF_TCTRL    = 3'd4;   // 0x10
    localparam logic [2:0] OFF_TSTAT    = 3'd5;   // 0x14

    // TIMER_CTRL bit positions
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_IRQ_BIT = 1;

    // Reset value of the compare register
    localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_timer
//  Description : Compare-match timer for the DMEM peripheral window: counter,
//                compare, control and sticky match flag, plus level IRQ.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_timer
    import dmem_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        i_wr_en,
    input  logic [2:0]  i_off,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_rd_data,
    output logic        o_irq
);

    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic [1:0]  r_ctrl;
    logic        r_flag;

    logic w_wr_count;
    logic w_wr_cmp;
    logic w_wr_ctrl;
    logic w_clr_flag;
    logic w_match;

    assign w_wr_count = i_wr_en && (i_off == OFF_TCOUNT);
    assign w_wr_cmp   = i_wr_en && (i_off == OFF_TCMP);
    assign w_wr_ctrl  = i_wr_en && (i_off == OFF_TCTRL);
    assign w_clr_flag = i_wr_en && (i_off == OFF_TSTAT) && i_wr_data[0];

    // Match is judged on the register values of the current cycle
    assign w_match = r_ctrl[CTRL_EN_BIT] && (r_count == r_cmp);

    // Counter: a bus load takes priority over the free-running increment
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= i_wr_data;
        end else if (r_ctrl[CTRL_EN_BIT]) begin
            r_count <= r_count + 32'd1;
        end
    end

    // Compare and control registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cmp  <= TCMP_RESET;
            r_ctrl <= '0;
        end else begin
            if (w_wr_cmp) begin
                r_cmp <= i_wr_data;
            end
            if (w_wr_ctrl) begin
                r_ctrl <= i_wr_data[1:0];
            end
        end
    end

    // Sticky match flag: a new match beats a simultaneous write-1-clear
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_flag <= 1'b0;
        end else if (w_match) begin
            r_flag <= 1'b1;
        end else if (w_clr_flag) begin
            r_flag <= 1'b0;
        end
    end

    // IRQ is the AND of two registered bits, so it is glitch-free
    assign o_irq = r_flag & r_ctrl[CTRL_IRQ_BIT];

    // Read mux; non-timer offsets return 0
    always_comb begin
        o_rd_data = '0;
        case (i_off)
            OFF_TCOUNT: o_rd_data = r_count;
            OFF_TCMP:   o_rd_data = r_cmp;
            OFF_TCTRL:  o_rd_data = {30'd0, r_ctrl};
            OFF_TSTAT:  o_rd_data = {31'd0, r_flag};
            default:    o_rd_data = '0;
        endcase
    end

endmodule : dmem_timer
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : DMEM bus responder: word RAM with combinational read, plus a
//                peripheral window holding GPIO and an optional timer.
//                Define DMEM_TIMER_EN to build the timer (offsets 0x08-0x14
//                and TIMER_IRQ); otherwise they read 0 and TIMER_IRQ is 0.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS   = 1024,
    parameter logic [31:0] PERIPH_BASE = DEFAULT_PERIPH_BASE
)(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] DIR_DMEM,
    input  logic [31:0] DATA_WRITE_DMEM,
    input  logic        READ,
    input  logic        WRITE,
    output logic [31:0] DATA_READ_DMEM,
    input  logic [31:0] GPIO_IN,
    output logic [31:0] GPIO_OUT,
    output logic        TIMER_IRQ
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0] r_ram [RAM_WORDS];
    logic [31:0] r_gpio_out;
    logic [31:0] r_gpio_meta;
    logic [31:0] r_gpio_sync;

    logic          w_ram_hit;
    logic [AW-1:0] w_ram_idx;
    logic          w_periph_hit;
    logic [2:0]    w_off;
    logic          w_wr_periph;
    logic [31:0]   w_timer_rdata;
    logic          w_unused_addr;

    // Byte-lane bits are ignored: accesses are whole words
    assign w_unused_addr = &{1'b0, DIR_DMEM[1:0]};

    // RAM_WORDS is a power of two, so "below RAM size" is all-zero upper bits
    assign w_ram_hit    = (DIR_DMEM[31:AW+2] == '0);
    assign w_ram_idx    = DIR_DMEM[AW+1:2];
    assign w_periph_hit = (DIR_DMEM[31:5] == PERIPH_BASE[31:5]);
    assign w_off        = DIR_DMEM[4:2];
    assign w_wr_periph  = WRITE && w_periph_hit;

    // RAM write port; contents are intentionally not reset
    always_ff @(posedge CLK) begin
        if (WRITE && w_ram_hit) begin
            r_ram[w_ram_idx] <= DATA_WRITE_DMEM;
        end
    end

    // GPIO output register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_gpio_out <= '0;
        end else if (w_wr_periph && (w_off == OFF_GPIO_OUT)) begin
            r_gpio_out <= DATA_WRITE_DMEM;
        end
    end

    // Two-flop synchronizer for the asynchronous GPIO inputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_gpio_meta <= '0;
            r_gpio_sync <= '0;
        end else begin
            r_gpio_meta <= GPIO_IN;
            r_gpio_sync <= r_gpio_meta;
        end
    end

    assign GPIO_OUT = r_gpio_out;

`ifdef DMEM_TIMER_EN
    dmem_timer u_timer (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .i_wr_en   (w_wr_periph),
        .i_off     (w_off),
        .i_wr_data (DATA_WRITE_DMEM),
        .o_rd_data (w_timer_rdata),
        .o_irq     (TIMER_IRQ)
    );
`else
    assign w_timer_rdata = '0;
    assign TIMER_IRQ     = 1'b0;
`endif

    // Combinational read mux; shows pre-write data when READ and WRITE coincide
    always_comb begin
        DATA_READ_DMEM = '0;
        if (READ) begin
            if (w_ram_hit) begin
                DATA_READ_DMEM = r_ram[w_ram_idx];
            end else if (w_periph_hit) begin
                case (w_off)
                    OFF_GPIO_OUT: DATA_READ_DMEM = r_gpio_out;
                    OFF_GPIO_IN:  DATA_READ_DMEM = r_gpio_sync;
                    default:      DATA_READ_DMEM = w_timer_rdata;
                endcase
            end
        end
    end

endmodule : dmem_responder
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core: it answers the core's DMEM bus (address, write data, READ/WRITE strobes, read data) with a word-addressed RAM plus a small memory-mapped peripheral window (GPIO and a compare-match timer). It sits at the top level beside the instruction ROM, wired directly to the core's DMEM ports. Reads are combinational so the core needs no stall. Writes commit on the clock edge.

## Interface
- RAM_WORDS, 1024: RAM depth in 32-bit words; must be a power of two.
- PERIPH_BASE, 32'h0001_0000: base byte address of the peripheral window; must be 32-byte aligned and above the RAM range.
- CLK  in  1  core clock; all state updates on the rising edge.
- RESET_N  in  1  reset RESET_N, asynchronous, active-low; clock CLK.
- DIR_DMEM  in  32  byte address from the core; bits [1:0] ignored (word access only).
- DATA_WRITE_DMEM  in  32  write data.
- READ  in  1  read strobe.
- WRITE  in  1  write strobe.
- DATA_READ_DMEM  out  32  read data, combinational.
- GPIO_IN  in  32  external inputs, asynchronous to CLK.
- GPIO_OUT  out  32  registered output port.
- TIMER_IRQ  out  1  level interrupt: match flag AND irq-enable.

## Operation
- Decode:
  - RAM hit when DIR_DMEM < RAM_WORDS*4, indexed by DIR_DMEM[log2(RAM_WORDS)+1:2].
  - Peripheral hit when DIR_DMEM[31:5] == PERIPH_BASE[31:5]; register offset is DIR_DMEM[4:2].
  - Anything else is unmapped.
- Peripheral registers, by byte offset from PERIPH_BASE:
  - 0x00 GPIO_OUT, RW.
  - 0x04 GPIO_IN, RO: the value after a 2-flop synchronizer.
  - 0x08 TIMER_COUNT, RW: a write loads the counter.
  - 0x0C TIMER_CMP, RW.
  - 0x10 TIMER_CTRL, RW: bit0 count enable, bit1 irq enable, other bits read 0.
  - 0x14 TIMER_STAT: bit0 match flag; write 1 to clear, write 0 has no effect.
  - Offsets 0x18 and 0x1C read 0; writes to them are ignored.
- Reads:
  - When READ=1, DATA_READ_DMEM is the addressed word.
  - When READ=0, or the address is unmapped, DATA_READ_DMEM = 0.
- Writes: when WRITE=1, the addressed RAM word or register updates at the next rising edge. Unmapped writes and writes to GPIO_IN are ignored.
- READ and WRITE both high: the write is performed, and DATA_READ_DMEM shows the pre-write value during that cycle.
- Timer counter:
  - When the enable bit is set, TIMER_COUNT increments by 1 each cycle and wraps from 0xFFFF_FFFF to 0.
  - A bus write to TIMER_COUNT in the same cycle overrides the increment.
- Match flag:
  - Sets on the edge after a cycle in which count enable=1 and TIMER_COUNT==TIMER_CMP. The comparison uses current register values.
  - If a set and a write-1-clear occur in the same cycle, set wins.
- RAM contents are not reset; they are undefined until written.

## Timing
- Reset values: GPIO_OUT=0, TIMER_COUNT=0, TIMER_CMP=0xFFFF_FFFF, TIMER_CTRL=0, match flag=0, synchronizer flops=0, TIMER_IRQ=0.
- DATA_READ_DMEM is 0 during reset because READ from the core is 0.
- Read latency is 0 cycles (combinational from DIR_DMEM/READ).
- Write latency is 1 edge: the new value is visible to a read in the following cycle.
- GPIO_IN latency: a change is visible at offset 0x04 after 2 rising edges.
- TIMER_IRQ is registered from the flag and enable bits, combined with an AND after the registers; it rises in the cycle after the match cycle.
- Reset asserted mid-operation returns all registers to their reset values immediately (asynchronous). A write in flight is dropped.

## Configuration
- DMEM_TIMER_EN defined: timer registers (0x08–0x14) and TIMER_IRQ are implemented as above.
- DMEM_TIMER_EN undefined:
  - No timer logic is built.
  - Offsets 0x08–0x14 read 0 and ignore writes.
  - TIMER_IRQ is tied to 0.
  - The TIMER_IRQ port remains present.

## Structure
- Shared package dmem_pkg:
  - Register offset constants (OFF_GPIO_OUT, OFF_GPIO_IN, OFF_TCOUNT, OFF_TCMP, OFF_TCTRL, OFF_TSTAT).
  - TIMER_CTRL bit positions.
  - Default PERIPH_BASE.
- One sub-module, dmem_timer:
  - Holds the counter, compare, control and flag registers and the IRQ logic.
  - Inputs: write strobe, offset and data.
  - Outputs: read mux data and IRQ.
  - Instantiated only under DMEM_TIMER_EN.
- The top module holds the RAM array, the decode logic, GPIO and the synchronizer.

## Test plan
- RAM round trip: write 0xDEADBEEF to 0x0000_0010, then read 0x10 → 0xDEADBEEF. Read 0x13 → the same word (bits [1:0] ignored).
- Unmapped and strobe behaviour: read PERIPH_BASE+0x18 → 0. Read 0x0FFF_0000 → 0. READ=0 at any address → 0.
- GPIO:
  - Write 0xA5A5_0001 to GPIO_OUT → the pin shows it after 1 edge.
  - Drive GPIO_IN=0x1234 → offset 0x04 reads 0 for 2 edges, then 0x1234.
- Timer match:
  - Setup: TCMP=5, TCOUNT=0, CTRL=0b11.
  - Flag set on the edge after count==5; TIMER_IRQ=1 in the following cycle.
  - Write 1 to STAT → flag and IRQ clear.
- Timer wrap and priority:
  - Load TCOUNT=0xFFFF_FFFF with enable on → reads 0 next cycle.
  - A bus write of 7 in the same cycle as an increment → reads 7.
- Asynchronous reset mid-count: assert RESET_N=0 between edges → GPIO_OUT=0, TCOUNT=0, TIMER_IRQ=0 immediately. With DMEM_TIMER_EN undefined, timer reads → 0.
